output_pulse_gen: RTL

//   Output-side counterpart of the push-button input conditioning: turns a one-cycle

---
 rtl/output_pulse_gen.sv | 131 +++++++++++++
 1 files changed

// File: rtl/output_pulse_gen.sv
// Pulse-train generator for an output pin. A one-cycle start request launches a train of
// num_pulses high pulses, each high_cycles long, separated by low_cycles (minimum one)
// of low time. All outputs come straight from flops.
module output_pulse_gen #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned N_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] high_cycles,
    input  logic [CNT_W-1:0] low_cycles,
    input  logic [N_W-1:0]   num_pulses,
    output logic             pulse_out,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
    localparam logic [N_W-1:0]   NumOne = N_W'(1);

    typedef enum logic [1:0] {
        StIdle,
        StHigh,
        StLow,
        StFin
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [N_W-1:0]   pcnt_q, pcnt_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] low_q, low_d;
    logic             pulse_out_q, pulse_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Low phase length minus one; a zero low time still gives one low cycle.
    logic [CNT_W-1:0] low_reload;
    assign low_reload = (low_q == '0) ? '0 : (low_q - CntOne);

    // Next-state, counter and output decode.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        pcnt_d      = pcnt_q;
        high_d      = high_q;
        low_d       = low_q;

        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    high_d = high_cycles;
                    low_d  = low_cycles;
                    if (num_pulses == '0 || high_cycles == '0) begin
                        state_d = StFin;
                    end else begin
                        state_d = StHigh;
                        phase_d = high_cycles - CntOne;
                        pcnt_d  = num_pulses - NumOne;
                    end
                end
            end
            StHigh: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (phase_q == '0) begin
                    if (pcnt_q == '0) begin
                        state_d = StFin;
                    end else begin
                        state_d = StLow;
                        phase_d = low_reload;
                        pcnt_d  = pcnt_q - NumOne;
                    end
                end else begin
                    phase_d = phase_q - CntOne;
                end
            end
            StLow: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (phase_q == '0) begin
                    state_d = StHigh;
                    phase_d = high_q - CntOne;
                end else begin
                    phase_d = phase_q - CntOne;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are registered copies of the decoded next state.
        pulse_out_d = (state_d == StHigh);
        busy_d      = (state_d == StHigh) || (state_d == StLow);
        done_d      = (state_d == StFin);
    end

    // State, counters, latched operands and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            phase_q     <= '0;
            pcnt_q      <= '0;
            high_q      <= '0;
            low_q       <= '0;
            pulse_out_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            pcnt_q      <= pcnt_d;
            high_q      <= high_d;
            low_q       <= low_d;
            pulse_out_q <= pulse_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign pulse_out = pulse_out_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
